// File: rtl/odd_counter_sequencer.sv
// Command sequencer that walks an odd up/down counter to a requested odd target, one step per two clocks.
// Optional per-step movement check of the counter is enabled with `define ODD_SEQ_STEPCHECK_EN.
module odd_counter_sequencer #(
    parameter int N = 4
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         CmdValid,
    output logic         CmdReady,
    input  logic [N-1:0] CmdTarget,
    input  logic         Abort,
    input  logic [N-1:0] CntQ,
    output logic         CntEnable,
    output logic         CntUp,
    output logic         Busy,
    output logic         Done,
    output logic [1:0]   ErrCode,
    output logic [N-1:0] StepCount
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CMP,
        S_STEP,
        S_DONE
    } state_t;

    localparam logic [1:0] ERR_OK       = 2'b00;
    localparam logic [1:0] ERR_EVEN     = 2'b01;
    localparam logic [1:0] ERR_ABORT    = 2'b10;
    localparam logic [1:0] ERR_MISMATCH = 2'b11;

    state_t       state_reg, state_next;
    logic [N-1:0] target_reg, target_next;
    logic         up_reg, up_next;
    logic [N-1:0] step_count_reg, step_count_next;
    logic [1:0]   err_reg, err_next;

`ifdef ODD_SEQ_STEPCHECK_EN
    // Q seen while the last step was issued; stepped_reg marks that a step has happened
    // in this command, so the first compare after accept is not checked.
    logic [N-1:0] prev_q_reg, prev_q_next;
    logic         stepped_reg, stepped_next;
    logic [N-1:0] expect_q;
    logic         step_bad;

    assign expect_q = up_reg ? (prev_q_reg + N'(2)) : (prev_q_reg - N'(2));
    assign step_bad = stepped_reg && (CntQ != expect_q);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            prev_q_reg  <= '0;
            stepped_reg <= 1'b0;
        end else begin
            prev_q_reg  <= prev_q_next;
            stepped_reg <= stepped_next;
        end
    end
`endif

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_reg      <= S_IDLE;
            target_reg     <= '0;
            up_reg         <= 1'b0;
            step_count_reg <= '0;
            err_reg        <= ERR_OK;
        end else begin
            state_reg      <= state_next;
            target_reg     <= target_next;
            up_reg         <= up_next;
            step_count_reg <= step_count_next;
            err_reg        <= err_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        target_next     = target_reg;
        up_next         = up_reg;
        step_count_next = step_count_reg;
        err_next        = err_reg;
        CntEnable       = 1'b0;
`ifdef ODD_SEQ_STEPCHECK_EN
        prev_q_next     = prev_q_reg;
        stepped_next    = stepped_reg;
`endif
        case (state_reg)
            S_IDLE: begin
                if (CmdValid) begin
                    target_next     = CmdTarget;
                    step_count_next = '0;
`ifdef ODD_SEQ_STEPCHECK_EN
                    stepped_next    = 1'b0;
`endif
                    if (!CmdTarget[0]) begin
                        err_next   = ERR_EVEN;
                        state_next = S_DONE;
                    end else begin
                        err_next   = ERR_OK;
                        state_next = S_CMP;
                    end
                end
            end
            S_CMP: begin
                // Abort outranks both a bad step and reaching the target.
                if (Abort) begin
                    err_next   = ERR_ABORT;
                    state_next = S_DONE;
`ifdef ODD_SEQ_STEPCHECK_EN
                end else if (step_bad) begin
                    err_next   = ERR_MISMATCH;
                    state_next = S_DONE;
`endif
                end else if (CntQ == target_reg) begin
                    err_next   = ERR_OK;
                    state_next = S_DONE;
                end else begin
                    up_next    = (target_reg > CntQ);
                    state_next = S_STEP;
                end
            end
            S_STEP: begin
                if (Abort) begin
                    err_next   = ERR_ABORT;
                    state_next = S_DONE;
                end else begin
                    CntEnable       = 1'b1;
                    step_count_next = step_count_reg + N'(1);
`ifdef ODD_SEQ_STEPCHECK_EN
                    prev_q_next     = CntQ;
                    stepped_next    = 1'b1;
`endif
                    state_next      = S_CMP;
                end
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    assign CmdReady  = (state_reg == S_IDLE);
    assign Busy      = (state_reg != S_IDLE);
    assign Done      = (state_reg == S_DONE);
    assign CntUp     = up_reg;
    assign ErrCode   = err_reg;
    assign StepCount = step_count_reg;

endmodule

// File: tb/tb_odd_counter_sequencer.sv
// Bench for odd_counter_sequencer: a behavioural odd counter plus a closed-form model of
// latency, step count, error code and final Q per command; directed cases then random commands.
module tb_odd_counter_sequencer;

    localparam int N = 4;
`ifdef ODD_SEQ_STEPCHECK_EN
    localparam bit STEPCHECK = 1'b1;
`else
    localparam bit STEPCHECK = 1'b0;
`endif

    logic         Clk = 1'b0;
    logic         Reset;
    logic         CmdValid;
    logic         CmdReady;
    logic [N-1:0] CmdTarget;
    logic         Abort;
    logic [N-1:0] CntQ;
    logic         CntEnable;
    logic         CntUp;
    logic         Busy;
    logic         Done;
    logic [1:0]   ErrCode;
    logic [N-1:0] StepCount;

    logic         stuck;
    logic [N-1:0] cnt_q;

    int cmp_count = 0;
    int err_count = 0;

    always #5 Clk = ~Clk;

    odd_counter_sequencer #(.N(N)) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .CmdValid  (CmdValid),
        .CmdReady  (CmdReady),
        .CmdTarget (CmdTarget),
        .Abort     (Abort),
        .CntQ      (CntQ),
        .CntEnable (CntEnable),
        .CntUp     (CntUp),
        .Busy      (Busy),
        .Done      (Done),
        .ErrCode   (ErrCode),
        .StepCount (StepCount)
    );

    // Odd up/down counter standing in for OddUpDownCounterN; 'stuck' ties its enable off.
    always_ff @(posedge Clk) begin
        if (Reset)
            cnt_q <= N'(1);
        else if (CntEnable && !stuck)
            cnt_q <= CntUp ? cnt_q + N'(2) : cnt_q - N'(2);
    end
    assign CntQ = cnt_q;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        cmp_count++;
        assert (obs === exp) else begin
            err_count++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Expected outcome of one command from Q=q0; k is the cycle after accept in which Abort
    // is raised (0 = never). Cycles alternate compare (odd) / step (even) until done.
    function automatic void model(input int q0, input int t, input int k, input bit stk,
                                  output int lat, output int err, output int steps,
                                  output int q1, output int up);
        int n;
        int limit;
        up = (t > q0) ? 1 : 0;
        if (t % 2 == 0) begin
            lat = 1; err = 1; steps = 0; q1 = q0;
            return;
        end
        n = ((t > q0) ? (t - q0) : (q0 - t)) / 2;
        if (stk && n > 0)
            limit = STEPCHECK ? 3 : 1000;
        else
            limit = 2 * n + 1;
        if (k >= 1 && k <= limit) begin
            lat = k + 1; err = 2; steps = (k - 1) / 2;
        end else if (stk && n > 0) begin
            lat = 4; err = 3; steps = 1;
        end else begin
            lat = 2 * n + 2; err = 0; steps = n;
        end
        if (stk)
            q1 = q0;
        else
            q1 = up ? q0 + 2 * steps : q0 - 2 * steps;
    endfunction

    task automatic run_cmd(input string tag, input int t, input int k, input bit hold);
        int q0, lat, err, steps, q1, up;
        int cyc, pulses, bad_dir, ready_busy;
        bit got;
        q0 = int'(cnt_q);
        model(q0, t, k, stuck, lat, err, steps, q1, up);
        @(posedge Clk); #1;
        CmdValid  = 1'b1;
        CmdTarget = t[N-1:0];
        @(negedge Clk);
        chk({tag, " ready"}, CmdReady, 1);
        @(posedge Clk); #1;
        if (hold) CmdTarget = N'(15);
        else      CmdValid  = 1'b0;
        cyc = 1; pulses = 0; bad_dir = 0; ready_busy = 0; got = 1'b0;
        while (!got && cyc <= 40) begin
            Abort = (cyc == k);
            @(negedge Clk);
            if (CntEnable === 1'b1) begin
                pulses++;
                if (CntUp !== up[0]) bad_dir++;
            end
            if (CmdReady !== 1'b0) ready_busy++;
            if (Done === 1'b1) begin
                got = 1'b1;
                CmdValid = 1'b0;
                chk({tag, " latency"}, cyc, lat);
                chk({tag, " err"}, ErrCode, err);
                chk({tag, " steps"}, StepCount, steps);
                chk({tag, " pulses"}, pulses, steps);
                chk({tag, " dir"}, bad_dir, 0);
                chk({tag, " ready_busy"}, ready_busy, 0);
                chk({tag, " busy"}, Busy, 1);
                chk({tag, " q"}, cnt_q, q1);
            end else begin
                @(posedge Clk); #1;
                cyc++;
            end
        end
        Abort = 1'b0;
        CmdValid = 1'b0;
        chk({tag, " done_seen"}, got, 1);
        @(posedge Clk); #1;
        @(negedge Clk);
        chk({tag, " idle"}, {Done, Busy, CmdReady}, 3'b001);
    endtask

    initial begin
        int t, k;
        bit h;
        int no_done;
        Reset = 1'b1; CmdValid = 1'b0; CmdTarget = '0; Abort = 1'b0; stuck = 1'b0;
        repeat (2) @(posedge Clk);
        #1 Reset = 1'b0;
        @(negedge Clk);
        chk("rst ready", CmdReady, 1);
        chk("rst busy", Busy, 0);
        chk("rst done", Done, 0);
        chk("rst enable", CntEnable, 0);
        chk("rst up", CntUp, 0);
        chk("rst err", ErrCode, 0);
        chk("rst steps", StepCount, 0);

        run_cmd("up7", 7, 0, 0);
        run_cmd("same7", 7, 0, 0);
        run_cmd("even6", 6, 0, 0);
        run_cmd("even0", 0, 0, 0);
        run_cmd("to9", 9, 0, 0);
        run_cmd("down1_hold", 1, 0, 1);
        run_cmd("abort_step3", 15, 6, 0);

        // Reset in the middle of a run: back to idle with reset outputs, no Done pulse.
        @(posedge Clk); #1;
        CmdValid = 1'b1; CmdTarget = N'(15);
        @(posedge Clk); #1;
        CmdValid = 1'b0;
        repeat (3) @(posedge Clk);
        #1 Reset = 1'b1;
        @(posedge Clk); #1 Reset = 1'b0;
        @(negedge Clk);
        chk("midrst outs", {CmdReady, Busy, Done, CntEnable, CntUp, ErrCode, StepCount},
            {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 4'd0});
        no_done = 0;
        repeat (4) begin
            @(negedge Clk);
            if (Done !== 1'b0) no_done++;
        end
        chk("midrst no_done", no_done, 0);

        stuck = 1'b1;
        run_cmd("stuck5", 5, STEPCHECK ? 0 : 7, 0);
        stuck = 1'b0;

        for (int i = 0; i < 40; i++) begin
            t = $urandom_range(0, 15);
            k = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 18) : 0;
            h = $urandom_range(0, 1);
            repeat ($urandom_range(0, 2)) @(posedge Clk);
            run_cmd($sformatf("rnd%0d", i), t, k, h);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, err_count);
        $finish;
    end

endmodule
